// File: rtl/lut_table_loader.sv
// Runtime-programmable LUT neuron: a double-buffered truth table loaded over a valid/ready
// config stream, with an atomic shadow->active commit and a 1-cycle pipelined lookup port.
module lut_table_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int CHUNK_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHUNK_W-1:0]  cfg_data,
    output logic                cfg_done,
    output logic                table_valid,
    input  logic                lk_valid,
    input  logic [IN_BITS-1:0]  lk_addr,
    output logic                lk_out_valid,
    output logic [OUT_BITS-1:0] lk_data
);
    localparam int DEPTH  = 1 << IN_BITS;
    localparam int NCHUNK = DEPTH * OUT_BITS / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t                         state_reg, state_next;
    logic [CNT_W-1:0]               cnt_reg, cnt_next;
    logic                           wr_en;
    logic [NCHUNK-1:0]              chunk_we;
    logic [NCHUNK-1:0][CHUNK_W-1:0] shadow_reg;
    logic [DEPTH-1:0][OUT_BITS-1:0] active_reg;
    logic                           table_valid_reg;
    logic                           lk_out_valid_reg;
    logic [OUT_BITS-1:0]            lk_data_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cfg_start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                // A restart wins over a handshake landing in the same cycle.
                if (cfg_start) begin
                    cnt_next = '0;
                end else if (cfg_valid) begin
                    wr_en = 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_next = COMMIT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_next = cfg_start ? LOAD : IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk_we
            assign chunk_we[gi] = wr_en && (cnt_reg == CNT_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            shadow_reg      <= '0;
            active_reg      <= '0;
            table_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            for (int i = 0; i < NCHUNK; i++) begin
                if (chunk_we[i]) begin
                    shadow_reg[i] <= cfg_data;
                end
            end
            // Shadow and active share the same flat bit layout, so commit is a plain copy.
            if (state_reg == COMMIT) begin
                active_reg      <= shadow_reg;
                table_valid_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_out_valid_reg <= 1'b0;
            lk_data_reg      <= '0;
        end else begin
            lk_out_valid_reg <= lk_valid;
            if (lk_valid) begin
                lk_data_reg <= active_reg[lk_addr];
            end
        end
    end

    assign cfg_ready    = (state_reg == LOAD);
    assign cfg_done     = (state_reg == COMMIT);
    assign table_valid  = table_valid_reg;
    assign lk_out_valid = lk_out_valid_reg;
    assign lk_data      = lk_data_reg;

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: load, paced load, double-buffer timing, restart, mid-load reset.
module tb_lut_table_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_done;
    logic       table_valid;
    logic       lk_valid = 1'b0;
    logic [5:0] lk_addr = 6'd0;
    logic       lk_out_valid;
    logic [0:0] lk_data;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [7:0] pat_a [8] = '{8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] pat_1 [8] = '{default: 8'hFF};
    logic [7:0] pat_0 [8] = '{default: 8'h00};

    lut_table_loader #(.IN_BITS(6), .OUT_BITS(1), .CHUNK_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_done     (cfg_done),
        .table_valid  (table_valid),
        .lk_valid     (lk_valid),
        .lk_addr      (lk_addr),
        .lk_out_valid (lk_out_valid),
        .lk_data      (lk_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cfg_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [5:0] a, input logic e, input string tag);
        lk_valid = 1'b1;
        lk_addr  = a;
        tick();
        lk_valid = 1'b0;
        check({tag, "_vld"}, 32'(lk_out_valid), 32'd1);
        check(tag, 32'(lk_data), 32'(e));
    endtask

    task automatic load_table(input logic [7:0] w [8], input bit gap, input string tag);
        int d0;
        d0 = done_cnt;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                cfg_valid = 1'b0;
                cfg_data  = 8'hA5;
                tick();
                check({tag, "_gap_done"}, 32'(cfg_done), 32'd0);
            end
            cfg_valid = 1'b1;
            cfg_data  = w[i];
            tick();
            check({tag, "_done_timing"}, 32'(cfg_done), 32'(i == 7));
        end
        cfg_valid = 1'b0;
        check({tag, "_ready_drop"}, 32'(cfg_ready), 32'd0);
        tick();
        check({tag, "_done_clear"}, 32'(cfg_done), 32'd0);
        check({tag, "_tvalid"}, 32'(table_valid), 32'd1);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_tvalid", 32'(table_valid), 32'd0);
        check("rst_lkv", 32'(lk_out_valid), 32'd0);
        check("rst_lkd", 32'(lk_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        lookup(6'd5, 1'b0, "empty_lk5");
        check("empty_tvalid", 32'(table_valid), 32'd0);

        // Basic load: 0x50 in chunk 1 sets entries 12 and 14
        load_table(pat_a, 1'b0, "loadA");
        for (int a = 0; a < 64; a++) begin
            lookup(6'(a), logic'(a == 12 || a == 14), $sformatf("loadA_lk%0d", a));
        end

        // Paced load with cfg_valid toggling
        load_table(pat_0, 1'b0, "clear");
        lookup(6'd12, 1'b0, "clear_lk12");
        load_table(pat_a, 1'b1, "paced");
        lookup(6'd12, 1'b1, "paced_lk12");
        lookup(6'd13, 1'b0, "paced_lk13");
        lookup(6'd14, 1'b1, "paced_lk14");
        lookup(6'd15, 1'b0, "paced_lk15");

        // Double-buffer: old table visible through the COMMIT cycle
        load_table(pat_1, 1'b0, "ones");
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'h00;
            lk_valid  = 1'b1;
            lk_addr   = 6'd63;
            tick();
            check("dbuf_load_lk63", 32'(lk_data), 32'd1);
        end
        cfg_valid = 1'b0;
        check("dbuf_commit_state", 32'(cfg_done), 32'd1);
        tick();
        check("dbuf_commit_lk63", 32'(lk_data), 32'd1);
        tick();
        lk_valid = 1'b0;
        check("dbuf_after_lk63", 32'(lk_data), 32'd0);
        check("dbuf_after_lkv", 32'(lk_out_valid), 32'd1);

        // Restart after 3 words; restart-cycle handshake must be ignored
        begin
            int d0;
            d0 = done_cnt;
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                cfg_valid = 1'b1;
                cfg_data  = 8'h5A;
                tick();
            end
            cfg_start = 1'b1;
            cfg_data  = 8'h00;
            tick();
            cfg_start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                cfg_valid = 1'b1;
                cfg_data  = 8'hFF;
                tick();
                check("restart_done_timing", 32'(cfg_done), 32'(i == 7));
            end
            cfg_valid = 1'b0;
            tick();
            check("restart_done_once", 32'(done_cnt - d0), 32'd1);
        end
        lookup(6'd0, 1'b1, "restart_lk0");
        lookup(6'd9, 1'b1, "restart_lk9");
        lookup(6'd31, 1'b1, "restart_lk31");
        lookup(6'd63, 1'b1, "restart_lk63");

        // Reset in the middle of a load
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'h00;
            lk_valid  = 1'b1;
            lk_addr   = 6'd0;
            tick();
        end
        check("premrst_lkv", 32'(lk_out_valid), 32'd1);
        check("premrst_lkd", 32'(lk_data), 32'd1);
        check("premrst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", 32'(cfg_ready), 32'd0);
        check("mrst_done", 32'(cfg_done), 32'd0);
        check("mrst_tvalid", 32'(table_valid), 32'd0);
        check("mrst_lkv", 32'(lk_out_valid), 32'd0);
        check("mrst_lkd", 32'(lk_data), 32'd0);
        cfg_valid = 1'b0;
        lk_valid  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        lookup(6'd63, 1'b0, "mrst_lk63");
        lookup(6'd0, 1'b0, "mrst_lk0");
        check("mrst_tvalid_after", 32'(table_valid), 32'd0);
        check("mrst_ready_after", 32'(cfg_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
